// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe turn sequencer: accepts moves over valid/ready, owns the board, declares win/draw.
// Optional turn timer enabled by defining MOVE_TIMEOUT_EN.
module ttt_game_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        move_valid,
    input  logic [3:0]  move_cell,
    output logic        move_ready,
    output logic [17:0] board,
    output logic        turn_o,
    output logic        illegal,
    output logic        win_o,
    output logic        win_x,
    output logic        draw,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_MOVE,
        S_CHECK,
        S_GAME_OVER
    } state_t;

    state_t      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic        turn_q, turn_d;
    logic [3:0]  move_count_q, move_count_d;
    logic        illegal_q, illegal_d;
    logic        win_o_q, win_o_d;
    logic        win_x_q, win_x_d;
    logic        draw_q, draw_d;
    logic        move_ready_q, move_ready_d;
    logic        busy_q, busy_d;

    logic [8:0]  o_cells;
    logic [8:0]  x_cells;
    logic [8:0]  cell_sel;
    logic [15:0] occupied;
    logic [17:0] mark_vec;
    logic [1:0]  mark;
    logic        handshake;
    logic        move_legal;
    logic        mover_wins;
    logic        timer_expire;

    // Per-cell views of the board: O is the high bit of a cell, X the low bit.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_cells
            assign o_cells[gi]            = board_q[17-2*gi];
            assign x_cells[gi]            = board_q[16-2*gi];
            assign cell_sel[gi]           = (move_cell == 4'(gi));
            assign mark_vec[17-2*gi -: 2] = cell_sel[gi] ? mark : 2'b00;
        end
    endgenerate

    function automatic logic has_line(input logic [8:0] c);
        has_line = (c[0] & c[1] & c[2]) | (c[3] & c[4] & c[5]) | (c[6] & c[7] & c[8]) |
                   (c[0] & c[3] & c[6]) | (c[1] & c[4] & c[7]) | (c[2] & c[5] & c[8]) |
                   (c[0] & c[4] & c[8]) | (c[2] & c[4] & c[6]);
    endfunction

    // Cells 9..15 read as occupied-free zeros; the range check rejects them anyway.
    assign occupied   = {7'b0, o_cells | x_cells};
    assign mark       = turn_q ? 2'b10 : 2'b01;
    assign handshake  = (state_q == S_WAIT_MOVE) && move_valid;
    assign move_legal = (move_cell <= 4'd8) && !occupied[move_cell];
    assign mover_wins = turn_q ? has_line(o_cells) : has_line(x_cells);

    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        turn_d       = turn_q;
        move_count_d = move_count_q;
        illegal_d    = 1'b0;
        win_o_d      = win_o_q;
        win_x_d      = win_x_q;
        draw_d       = draw_q;

        if (start) begin
            state_d      = S_WAIT_MOVE;
            board_d      = '0;
            turn_d       = 1'b1;
            move_count_d = '0;
            win_o_d      = 1'b0;
            win_x_d      = 1'b0;
            draw_d       = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    board_d      = '0;
                    turn_d       = 1'b1;
                    move_count_d = '0;
                end
                S_WAIT_MOVE: begin
                    if (handshake) begin
                        if (move_legal) begin
                            board_d = board_q | mark_vec;
                            if (move_count_q < 4'd9) begin
                                move_count_d = move_count_q + 4'd1;
                            end
                            state_d = S_CHECK;
                        end else begin
                            illegal_d = 1'b1;
                        end
                    end else if (timer_expire) begin
                        turn_d = ~turn_q;
                    end
                end
                S_CHECK: begin
                    if (mover_wins) begin
                        win_o_d = turn_q;
                        win_x_d = ~turn_q;
                        state_d = S_GAME_OVER;
                    end else if (move_count_q == 4'd9) begin
                        draw_d  = 1'b1;
                        state_d = S_GAME_OVER;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = S_WAIT_MOVE;
                    end
                end
                S_GAME_OVER: begin
                    state_d = S_GAME_OVER;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Status outputs are registered from the next state so they line up with it.
        move_ready_d = (state_d == S_WAIT_MOVE);
        busy_d       = (state_d == S_WAIT_MOVE) || (state_d == S_CHECK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            board_q      <= '0;
            turn_q       <= 1'b1;
            move_count_q <= '0;
            illegal_q    <= 1'b0;
            win_o_q      <= 1'b0;
            win_x_q      <= 1'b0;
            draw_q       <= 1'b0;
            move_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            turn_q       <= turn_d;
            move_count_q <= move_count_d;
            illegal_q    <= illegal_d;
            win_o_q      <= win_o_d;
            win_x_q      <= win_x_d;
            draw_q       <= draw_d;
            move_ready_q <= move_ready_d;
            busy_q       <= busy_d;
        end
    end

`ifdef MOVE_TIMEOUT_EN
    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               timeout_q, timeout_d;

    assign timer_expire = (state_q == S_WAIT_MOVE) &&
                          (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    // Any handshake or arrival in WAIT_MOVE restarts the turn; a handshake beats expiry.
    always_comb begin
        timer_d   = timer_q + 1'b1;
        timeout_d = 1'b0;
        if (start || (state_q != S_WAIT_MOVE) || handshake) begin
            timer_d = '0;
        end else if (timer_expire) begin
            timer_d   = '0;
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timer_expire = 1'b0;
    assign timeout      = 1'b0;
`endif

    assign move_ready = move_ready_q;
    assign board      = board_q;
    assign turn_o     = turn_q;
    assign illegal    = illegal_q;
    assign win_o      = win_o_q;
    assign win_x      = win_x_q;
    assign draw       = draw_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Self-checking bench for ttt_game_ctrl: directed vector table, corner sequences and a
// randomized run against a cell-array reference model.
module tb_ttt_game_ctrl;

    localparam int TO_CYC = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        move_valid;
    logic [3:0]  move_cell;
    logic        move_ready;
    logic [17:0] board;
    logic        turn_o;
    logic        illegal;
    logic        win_o;
    logic        win_x;
    logic        draw;
    logic        busy;
    logic        timeout;

    int n_total = 0;
    int n_pass  = 0;

    ttt_game_ctrl #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .move_valid(move_valid),
        .move_cell (move_cell),
        .move_ready(move_ready),
        .board     (board),
        .turn_o    (turn_o),
        .illegal   (illegal),
        .win_o     (win_o),
        .win_x     (win_x),
        .draw      (draw),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        s;
        logic        v;
        logic [3:0]  c;
        logic [17:0] b;
        logic        t;
        logic        rdy;
        logic        bsy;
        logic        ill;
        logic        wo;
        logic        wx;
        logic        dr;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_cycle(input logic s, input logic v, input logic [3:0] c);
        start      = s;
        move_valid = v;
        move_cell  = c;
        @(posedge clk);
        #1;
        start      = 1'b0;
        move_valid = 1'b0;
    endtask

    function automatic logic [24:0] obs();
        return {board, turn_o, move_ready, busy, illegal, win_o, win_x, draw};
    endfunction

    // ---------------- reference model ----------------
    int m_cells[9];      // 0 empty, 1 O, 2 X
    int m_mode;          // 0 idle, 1 awaiting move, 2 judging last move, 3 finished
    bit m_turn;
    int m_cnt;
    bit m_ill, m_wo, m_wx, m_dr, m_to;
    int m_timer;
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic bit m_has_line(input int who);
        for (int l = 0; l < 8; l++) begin
            if (m_cells[lines[l][0]] == who && m_cells[lines[l][1]] == who &&
                m_cells[lines[l][2]] == who) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [17:0] m_board();
        logic [17:0] b = '0;
        for (int i = 0; i < 9; i++) begin
            if (m_cells[i] == 1) b[17-2*i] = 1'b1;
            if (m_cells[i] == 2) b[16-2*i] = 1'b1;
        end
        return b;
    endfunction

    function automatic logic [25:0] m_obs();
        return {m_board(), m_turn, (m_mode == 1), (m_mode == 1 || m_mode == 2),
                m_ill, m_wo, m_wx, m_dr, m_to};
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 9; i++) m_cells[i] = 0;
        m_turn = 1'b1; m_cnt = 0; m_wo = 0; m_wx = 0; m_dr = 0;
        m_ill = 0; m_to = 0; m_timer = 0;
    endtask

    task automatic m_step(input bit r, input bit s, input bit v, input int c);
        bit timer_on = 1'b0;
`ifdef MOVE_TIMEOUT_EN
        timer_on = 1'b1;
`endif
        if (r) begin
            m_clear(); m_mode = 0;
        end else if (s) begin
            m_clear(); m_mode = 1;
        end else begin
            m_ill = 0; m_to = 0;
            if (m_mode == 1) begin
                if (v) begin
                    m_timer = 0;
                    if (c <= 8 && m_cells[c] == 0) begin
                        m_cells[c] = m_turn ? 1 : 2;
                        if (m_cnt < 9) m_cnt++;
                        m_mode = 2;
                    end else begin
                        m_ill = 1;
                    end
                end else if (timer_on) begin
                    if (m_timer == TO_CYC - 1) begin
                        m_to = 1; m_turn = ~m_turn; m_timer = 0;
                    end else begin
                        m_timer++;
                    end
                end
            end else if (m_mode == 2) begin
                m_timer = 0;
                if (m_has_line(m_turn ? 1 : 2)) begin
                    m_wo = m_turn; m_wx = ~m_turn; m_mode = 3;
                end else if (m_cnt == 9) begin
                    m_dr = 1; m_mode = 3;
                end else begin
                    m_turn = ~m_turn; m_mode = 1;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; move_valid = 1'b0; move_cell = 4'd0;

        vecs[0]  = '{1'b1, 1'b0, 4'd0,  18'b00_00_00_00_00_00_00_00_00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 4'd0,  18'b10_00_00_00_00_00_00_00_00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 4'd5,  18'b10_00_00_00_00_00_00_00_00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 4'd0,  18'b10_00_00_00_00_00_00_00_00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 4'd12, 18'b10_00_00_00_00_00_00_00_00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 4'd3,  18'b10_00_00_01_00_00_00_00_00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 4'd0,  18'b10_00_00_01_00_00_00_00_00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 4'd1,  18'b10_10_00_01_00_00_00_00_00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 4'd0,  18'b10_10_00_01_00_00_00_00_00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 4'd4,  18'b10_10_00_01_01_00_00_00_00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 4'd0,  18'b10_10_00_01_01_00_00_00_00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 4'd2,  18'b10_10_10_01_01_00_00_00_00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 4'd0,  18'b10_10_10_01_01_00_00_00_00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 4'd5,  18'b10_10_10_01_01_00_00_00_00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(obs()), 32'({18'h0, 1'b1, 6'b0}));
        chk("reset_timeout", 32'(timeout), 32'd0);
        chk("reset_count", 32'(dut.move_count_q), 32'd0);
        rst = 1'b0;
        do_cycle(1'b0, 1'b1, 4'd0);
        chk("idle_ignores_move", 32'(obs()), 32'({18'h0, 1'b1, 6'b0}));

        // Win for O with illegal retries, table driven
        for (int i = 0; i < 14; i++) begin
            do_cycle(vecs[i].s, vecs[i].v, vecs[i].c);
            chk($sformatf("vec%0d", i), 32'(obs()),
                32'({vecs[i].b, vecs[i].t, vecs[i].rdy, vecs[i].bsy,
                     vecs[i].ill, vecs[i].wo, vecs[i].wx, vecs[i].dr}));
        end

        // Illegal retries on an occupied centre and an out-of-range cell
        do_cycle(1'b1, 1'b0, 4'd0);
        do_cycle(1'b0, 1'b1, 4'd4);
        do_cycle(1'b0, 1'b0, 4'd0);
        chk("ill_turn_x", 32'(turn_o), 32'd0);
        do_cycle(1'b0, 1'b1, 4'd4);
        chk("ill_occ_pulse", 32'({illegal, move_ready, turn_o}), 32'b110);
        chk("ill_occ_board", 32'(board), 32'(18'b00_00_00_00_10_00_00_00_00));
        do_cycle(1'b0, 1'b1, 4'd12);
        chk("ill_range_pulse", 32'({illegal, move_ready, turn_o}), 32'b110);
        chk("ill_range_board", 32'(board), 32'(18'b00_00_00_00_10_00_00_00_00));
        do_cycle(1'b0, 1'b0, 4'd0);
        chk("ill_one_cycle", 32'(illegal), 32'd0);
        do_cycle(1'b0, 1'b1, 4'd0);
        chk("ill_then_legal", 32'({board, move_ready}), 32'({18'b01_00_00_00_10_00_00_00_00, 1'b0}));

        // Draw
        do_cycle(1'b1, 1'b0, 4'd0);
        foreach (lines[0][k]) begin end
        begin
            int seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
            for (int i = 0; i < 9; i++) begin
                do_cycle(1'b0, 1'b1, 4'(seq[i]));
                do_cycle(1'b0, 1'b0, 4'd0);
            end
        end
        chk("draw_flags", 32'({win_o, win_x, draw, move_ready, busy}), 32'b00100);
        chk("draw_count", 32'(dut.move_count_q), 32'd9);
        chk("draw_board", 32'(board), 32'(18'b10_01_10_10_01_01_01_10_10));

        // start beats a simultaneous legal move
        do_cycle(1'b1, 1'b0, 4'd0);
        do_cycle(1'b0, 1'b1, 4'd0);
        do_cycle(1'b0, 1'b0, 4'd0);
        do_cycle(1'b1, 1'b1, 4'd5);
        chk("start_prio", 32'({board, turn_o, illegal, move_ready, busy}), 32'({18'h0, 4'b1011}));
        do_cycle(1'b1, 1'b1, 4'd12);
        chk("start_no_illegal", 32'({illegal, move_ready}), 32'b01);

        // rst while judging a move
        do_cycle(1'b0, 1'b1, 4'd2);
        chk("pre_rst_check", 32'({move_ready, busy}), 32'b01);
        rst = 1'b1;
        do_cycle(1'b0, 1'b0, 4'd0);
        rst = 1'b0;
        chk("rst_mid_check", 32'(obs()), 32'({18'h0, 1'b1, 6'b0}));
        chk("rst_mid_timeout", 32'(timeout), 32'd0);

`ifdef MOVE_TIMEOUT_EN
        do_cycle(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < TO_CYC - 1; i++) do_cycle(1'b0, 1'b0, 4'd0);
        chk("to_not_early", 32'({timeout, turn_o}), 32'b01);
        do_cycle(1'b0, 1'b0, 4'd0);
        chk("to_expire", 32'({timeout, turn_o, move_ready}), 32'b101);
        chk("to_board", 32'(board), 32'd0);
        for (int i = 0; i < TO_CYC - 1; i++) do_cycle(1'b0, 1'b0, 4'd0);
        do_cycle(1'b0, 1'b1, 4'd4);
        chk("to_hs_wins", 32'({timeout, move_ready, board}), 32'({2'b00, 18'b00_00_00_00_01_00_00_00_00}));
        do_cycle(1'b0, 1'b0, 4'd0);
        chk("to_hs_turn", 32'({turn_o, timeout}), 32'b10);
`endif

        // Randomized run against the reference model
        rst = 1'b1;
        do_cycle(1'b0, 1'b0, 4'd0);
        m_step(1'b1, 1'b0, 1'b0, 0);
        rst = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            bit r, s, v;
            int c;
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
            rst = r;
            m_step(r, s, v, c);
            do_cycle(s, v, 4'(c));
            rst = 1'b0;
            chk($sformatf("rand%0d", n), 32'({obs(), timeout}), 32'(m_obs()));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
